program_sequencer: RTL and testbench

//  Run controller for the single-cycle CPU core (PC, IM, RF, ALU, DM).

---
 rtl/program_sequencer_pkg.sv | 22 ++
 rtl/program_sequencer_if.sv | 32 +++
 rtl/program_sequencer_prog_addr_table.sv | 22 ++
 rtl/program_sequencer.sv | 104 ++++++++++
 tb/tb_program_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - state type, sizing constants and program address tables
package program_sequencer_pkg;

    localparam int SEQ_PC_BITS       = 10;
    localparam int SEQ_PROG_SEL_BITS = 2;
    localparam int SEQ_NUM_PROGS     = 3;
    localparam int SEQ_CNT_BITS      = 16;
    localparam int SEQ_MAX_CYCLES    = 65535;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        FAULT
    } seq_state_t;

    // Each program occupies [start, done]; the instruction at done is the halt marker.
    localparam logic [SEQ_PC_BITS-1:0] PROG_START [SEQ_NUM_PROGS] = '{10'd0,   10'd436, 10'd701};
    localparam logic [SEQ_PC_BITS-1:0] PROG_DONE  [SEQ_NUM_PROGS] = '{10'd435, 10'd700, 10'd1000};

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - host req/ack handshake bundle between host and run sequencer
interface program_sequencer_if #(
    parameter int PROG_SEL_BITS = 2,
    parameter int CNT_BITS      = 16
);

    logic                     req;
    logic [PROG_SEL_BITS-1:0] prog_sel;
    logic                     ack;
    logic                     err;
    logic                     busy;
    logic [CNT_BITS-1:0]      cycle_count;

    modport master (
        output req,
        output prog_sel,
        input  ack,
        input  err,
        input  busy,
        input  cycle_count
    );

    modport slave (
        input  req,
        input  prog_sel,
        output ack,
        output err,
        output busy,
        output cycle_count
    );

endinterface

// File: rtl/program_sequencer_prog_addr_table.sv
// rtl/program_sequencer_prog_addr_table.sv - program index to start/done address lookup
// Out-of-range indices return zero; the sequencer never latches one.
module program_sequencer_prog_addr_table
    import program_sequencer_pkg::*;
(
    input  logic [SEQ_PROG_SEL_BITS-1:0] prog_i,
    output logic [SEQ_PC_BITS-1:0]       start_addr_o,
    output logic [SEQ_PC_BITS-1:0]       done_addr_o
);

    always_comb begin
        start_addr_o = '0;
        done_addr_o  = '0;
        for (int i = 0; i < SEQ_NUM_PROGS; i++) begin
            if (prog_i == SEQ_PROG_SEL_BITS'(i)) begin
                start_addr_o = PROG_START[i];
                done_addr_o  = PROG_DONE[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - run controller for the single-cycle CPU core
// Accepts a host request, starts the selected program, gates execution, detects done and timeout.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PC_BITS       = SEQ_PC_BITS,
    parameter int PROG_SEL_BITS = SEQ_PROG_SEL_BITS,
    parameter int NUM_PROGS     = SEQ_NUM_PROGS,
    parameter int CNT_BITS      = SEQ_CNT_BITS,
    parameter int MAX_CYCLES    = SEQ_MAX_CYCLES
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    program_sequencer_if.slave       host,
    input  logic [PC_BITS-1:0]       pc_i,
    output logic                     cpu_start_o,
    output logic [PC_BITS-1:0]       start_addr_o,
    output logic                     cpu_run_en_o
);

    seq_state_t               state_q, state_d;
    logic [PROG_SEL_BITS-1:0] prog_q, prog_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;

    logic [SEQ_PC_BITS-1:0]   tbl_start;
    logic [SEQ_PC_BITS-1:0]   tbl_done;
    logic [PC_BITS-1:0]       done_addr;
    logic                     at_done;
    logic                     budget_spent;
    logic                     sel_legal;

    program_sequencer_prog_addr_table u_addr_table (
        .prog_i       (SEQ_PROG_SEL_BITS'(prog_q)),
        .start_addr_o (tbl_start),
        .done_addr_o  (tbl_done)
    );

    assign start_addr_o = PC_BITS'(tbl_start);
    assign done_addr    = PC_BITS'(tbl_done);

    assign at_done      = (pc_i == done_addr);
    assign budget_spent = (cnt_q == CNT_BITS'(MAX_CYCLES - 1));
    assign sel_legal    = (int'(host.prog_sel) < NUM_PROGS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only advances on cycles that stay in RUN, so the halt cycle is not counted.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (host.req) begin
                    if (sel_legal) begin
                        prog_d  = PROG_SEL_BITS'(host.prog_sel);
                        state_d = LOAD;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = host.req ? RUN : IDLE;
            end
            RUN: begin
                if (at_done) begin
                    state_d = DONE;
                end else if (budget_spent) begin
                    state_d = FAULT;
                end else if (!host.req) begin
                    state_d = IDLE;
                end else if (cnt_q != {CNT_BITS{1'b1}}) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            DONE, FAULT: begin
                if (!host.req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_start_o      = (state_q == LOAD);
    assign cpu_run_en_o     = (state_q == RUN) && !at_done;
    assign host.busy        = (state_q == LOAD) || (state_q == RUN);
    assign host.ack         = (state_q == DONE) || (state_q == FAULT);
    assign host.err         = (state_q == FAULT);
    assign host.cycle_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer with a PC model
module tb_program_sequencer;

    localparam int TO_MAX = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pc, pc_to;
    logic       cpu_start, cpu_start_to;
    logic [9:0] start_addr, start_addr_to;
    logic       run_en, run_en_to;

    int n_checks = 0;
    int n_fail   = 0;
    int starts_seen = 0;
    int last_cnt = 0;

    int prog_start_m [3] = '{0, 436, 701};
    int prog_done_m  [3] = '{435, 700, 1000};

    program_sequencer_if #(.PROG_SEL_BITS(2), .CNT_BITS(16)) h ();
    program_sequencer_if #(.PROG_SEL_BITS(2), .CNT_BITS(16)) ht ();

    program_sequencer u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .host         (h),
        .pc_i         (pc),
        .cpu_start_o  (cpu_start),
        .start_addr_o (start_addr),
        .cpu_run_en_o (run_en)
    );

    program_sequencer #(.MAX_CYCLES(TO_MAX)) u_dut_to (
        .clk_i        (clk),
        .rst_i        (rst),
        .host         (ht),
        .pc_i         (pc_to),
        .cpu_start_o  (cpu_start_to),
        .start_addr_o (start_addr_to),
        .cpu_run_en_o (run_en_to)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)            pc <= '0;
        else if (cpu_start) pc <= start_addr;
        else if (run_en)    pc <= pc + 10'd1;
    end

    // This PC gets stuck at 5, so its program can only end by timeout.
    always @(posedge clk) begin
        if (rst)                               pc_to <= '0;
        else if (cpu_start_to)                 pc_to <= start_addr_to;
        else if (run_en_to && pc_to != 10'd5)  pc_to <= pc_to + 10'd1;
    end

    always @(negedge clk) begin
        if (cpu_start) starts_seen <= starts_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the sequencer idle; leaves it idle at a negedge with req low.
    task automatic run_prog(input int p, input int drop_in, input int hold);
        int exp_start, exp_done, len, drop_at, exp_cnt, cyc, starts0;
        bit abort_exp;
        starts0 = starts_seen;
        h.req = 1'b1;
        h.prog_sel = 2'(p);
        @(negedge clk);
        if (p >= 3) begin
            check("illegal_ack", h.ack, 1);
            check("illegal_err", h.err, 1);
            check("illegal_busy", h.busy, 0);
            exp_cnt = last_cnt;
            abort_exp = 1'b0;
        end else begin
            exp_start = prog_start_m[p];
            exp_done  = prog_done_m[p];
            len       = exp_done - exp_start;
            drop_at   = (drop_in >= 0 && drop_in < len) ? drop_in : -1;
            abort_exp = (drop_at >= 0);
            exp_cnt   = abort_exp ? drop_at : len;
            check("load_start", cpu_start, 1);
            check("load_busy", h.busy, 1);
            check("load_addr", start_addr, exp_start);
            @(negedge clk);
            check("pc_loaded", pc, exp_start);
            cyc = 0;
            while (h.busy && cyc < 3000) begin
                if (int'(pc) == exp_done) begin
                    check("run_en_at_done", run_en, 0);
                    check("count_at_done", h.cycle_count, len);
                end
                if (drop_at >= 0 && int'(h.cycle_count) == drop_at) h.req = 1'b0;
                @(negedge clk);
                cyc++;
            end
            check("run_bounded", h.busy, 0);
            check("end_ack", h.ack, !abort_exp);
            check("end_err", h.err, 0);
            check("end_count", h.cycle_count, exp_cnt);
            if (abort_exp) check("abort_run_en", run_en, 0);
        end
        check("start_pulses", starts_seen - starts0, (p >= 3) ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ack", h.ack, !abort_exp);
        end
        h.req = 1'b0;
        @(negedge clk);
        check("release_ack", h.ack, 0);
        check("release_err", h.err, 0);
        check("release_busy", h.busy, 0);
        check("release_count", h.cycle_count, exp_cnt);
        last_cnt = exp_cnt;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, p, drop, hold;
        rst = 1'b1;
        h.req = 1'b0;  h.prog_sel = '0;
        ht.req = 1'b0; ht.prog_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", h.ack, 0);
        check("rst_err", h.err, 0);
        check("rst_busy", h.busy, 0);
        check("rst_start", cpu_start, 0);
        check("rst_run_en", run_en, 0);
        check("rst_count", h.cycle_count, 0);
        check("rst_addr", start_addr, 0);

        run_prog(0, -1, 0);
        run_prog(3, -1, 2);

        h.req = 1'b1; h.prog_sel = 2'd1;
        @(negedge clk);
        check("ld_abort_start", cpu_start, 1);
        check("ld_abort_addr", start_addr, 436);
        h.req = 1'b0;
        @(negedge clk);
        check("ld_abort_busy", h.busy, 0);
        check("ld_abort_ack", h.ack, 0);
        check("ld_abort_count", h.cycle_count, 0);
        last_cnt = 0;

        run_prog(1, 10, 0);

        h.req = 1'b1; h.prog_sel = 2'd2;
        cyc = 0;
        while (!(h.busy && h.cycle_count == 16'd50) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_run_reached", h.cycle_count, 50);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", h.busy, 0);
        check("mid_rst_ack", h.ack, 0);
        check("mid_rst_err", h.err, 0);
        check("mid_rst_count", h.cycle_count, 0);
        check("mid_rst_addr", start_addr, 0);
        check("mid_rst_run_en", run_en, 0);
        rst = 1'b0;
        h.req = 1'b0;
        last_cnt = 0;
        @(negedge clk);
        run_prog(2, -1, 0);

        run_prog(0, -1, 5);
        run_prog(1, -1, 0);

        ht.req = 1'b1; ht.prog_sel = 2'd0;
        cyc = 0;
        @(negedge clk);
        while (!ht.ack && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("to_ack", ht.ack, 1);
        check("to_err", ht.err, 1);
        check("to_count", ht.cycle_count, TO_MAX - 1);
        check("to_pc", pc_to, 5);
        repeat (3) @(negedge clk);
        check("to_hold_count", ht.cycle_count, TO_MAX - 1);
        check("to_hold_err", ht.err, 1);
        ht.req = 1'b0;
        @(negedge clk);
        check("to_release_ack", ht.ack, 0);

        for (int it = 0; it < 8; it++) begin
            p    = int'($urandom_range(0, 3));
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 300)) : -1;
            hold = int'($urandom_range(0, 4));
            run_prog(p, drop, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
